// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory port between instruction fetch and the MEM-stage
// load/store path, sequencing each access as a held req/ack bus transaction.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stall_req
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, INST, RESP} state_t;
  typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

  state_t     state;
  grant_t     last_grant;
  grant_t     owner;
  logic [7:0] wait_cnt;
  logic       fetch_killed;

  logic inst_ok;
  logic pick_data;
  logic pick_inst;
  logic kill_now;
  logic timed_out;

  assign stall_req = (data_req & ~data_ready) | (inst_req & ~inst_ready);

  // Data wins a collision unless it was the last one served, so neither side starves.
  always_comb begin
    inst_ok   = inst_req & ~flush;
    pick_data = data_req & (~inst_ok | (last_grant == GRANT_INST));
    pick_inst = inst_ok & ~pick_data;
    kill_now  = fetch_killed | flush;
    timed_out = (wait_cnt == LAST_WAIT);
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      last_grant   <= GRANT_INST;
      owner        <= GRANT_INST;
      wait_cnt     <= '0;
      fetch_killed <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_ready   <= 1'b0;
      data_ready   <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt     <= '0;
          fetch_killed <= 1'b0;
          if (pick_data) begin
            bus_req   <= 1'b1;
            bus_we    <= data_we;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            owner     <= GRANT_DATA;
            state     <= DATA;
          end else if (pick_inst) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
            owner     <= GRANT_INST;
            state     <= INST;
          end
        end
        DATA: begin
          if (bus_ack) begin
            bus_req    <= 1'b0;
            data_ready <= 1'b1;
            if (!bus_we) data_rdata <= bus_rdata;
            state      <= RESP;
          end else if (timed_out) begin
            bus_req    <= 1'b0;
            data_ready <= 1'b1;
            bus_err    <= 1'b1;
            data_rdata <= '0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        INST: begin
          // A flushed fetch still finishes on the bus; only the ready pulse is withheld.
          if (flush) fetch_killed <= 1'b1;
          if (bus_ack) begin
            bus_req    <= 1'b0;
            inst_rdata <= bus_rdata;
            inst_ready <= ~kill_now;
            state      <= RESP;
          end else if (timed_out) begin
            bus_req    <= 1'b0;
            inst_rdata <= '0;
            inst_ready <= ~kill_now;
            bus_err    <= ~kill_now;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
